// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// Owner and FSM state encodings used by mem_port_arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between fetch and load/store ports.
// Data wins by default; a starve counter eventually forces fetch through.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int LW = $clog2(MEM_LATENCY + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            we_q, we_d;
  logic            kill_q, kill_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic idle, starved, fetch_win;
  logic grant, own_req, done, cpl;

  assign idle      = (state_q == IDLE);
  assign starved   = (starve_q == SW'(STARVE_LIMIT));
  assign fetch_win = if_req && (!d_req || starved);
  assign grant     = idle && (if_req || d_req) && !rst;
  assign own_req   = (owner_q == OWN_DATA) ? d_req : if_req;
  assign done      = !idle && (we_q || lat_q == '0);
  // A requester that let go mid-access never sees its ready.
  assign cpl       = done && own_req && !kill_q && !rst;

  assign if_ready  = cpl && (owner_q == OWN_FETCH);
  assign d_ready   = cpl && (owner_q == OWN_DATA);
  assign if_rdata  = if_ready ? mem_rdata : '0;
  assign d_rdata   = d_ready ? mem_rdata : '0;

  assign mem_en    = grant;
  assign mem_we    = grant && !fetch_win && d_we;
  assign mem_addr  = !grant ? '0 :
                     fetch_win ? if_addr : d_addr;
  assign mem_wdata = (grant && !fetch_win) ? d_wdata : '0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    kill_d   = kill_q;
    lat_d    = lat_q;
    starve_d = starve_q;

    if (!if_req) begin
      starve_d = '0;
    end else if (grant && fetch_win) begin
      starve_d = '0;
    end else if (grant && !starved) begin
      starve_d = starve_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = BUSY;
          owner_d = fetch_win ? OWN_FETCH : OWN_DATA;
          we_d    = !fetch_win && d_we;
          kill_d  = 1'b0;
          lat_d   = (!fetch_win && d_we) ? '0 :
                    LW'(MEM_LATENCY - 1);
        end
      end
      BUSY: begin
        if (!own_req) kill_d = 1'b1;
        if (done) begin
          state_d = IDLE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_FETCH;
      we_q     <= 1'b0;
      kill_q   <= 1'b0;
      lat_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      kill_q   <= kill_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch port and its data (load/store) port. Sits between the fetch/memory stages and the memory array. Runs one access at a time through a small state machine, favouring data over fetch with a starvation guard. Its ready signals feed the hazard unit, which stalls the waiting stage.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data word width
- MEM_LATENCY, 2, cycles from read issue to valid `mem_rdata`; must be ≥ 1
- STARVE_LIMIT, 4, consecutive lost fetch arbitrations before fetch is forced to win; must be ≥ 1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held until `if_ready`
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetched word; valid only while `if_ready`=1
- if_ready  out  1  fetch completion pulse
- d_req  in  1  data request; held until `d_ready`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_rdata  out  DATA_WIDTH  load data; valid only while `d_ready`=1
- d_ready  out  1  data completion pulse
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by `mem_en`
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  read data, valid MEM_LATENCY cycles after the `mem_en` cycle

## Operation
- States: IDLE, BUSY. Registers: owner (FETCH/DATA), captured we, latency counter, starve counter.
- IDLE with any request: grant, drive `mem_en`=1 and `mem_*` combinationally from the winner's inputs, capture owner and we, load counter, go to BUSY. IDLE with no request: `mem_en`=0, stay.
- Winner: data if `d_req`, unless `if_req` and starve counter == STARVE_LIMIT, in which case fetch wins.
- Starve counter: increments when both request in IDLE and data wins; clears when fetch is granted or when `if_req`=0; saturates at STARVE_LIMIT.
- Read: counter loads MEM_LATENCY-1. It decrements each BUSY cycle. Completion is the BUSY cycle with counter == 0.
- Write: counter loads 0, so completion is the first BUSY cycle.
- Completion cycle: ready of owner = 1 if that owner's req is still high. Corresponding rdata = `mem_rdata`. Return to IDLE. No new grant in this cycle.
- Requester drops req before completion (flush): access still completes on the memory side. Its ready stays 0, and the FSM still waits for completion before returning to IDLE.
- Address/data changes during BUSY do not affect the in-flight access; `mem_*` are driven only in the grant cycle.
- `if_rdata`/`d_rdata` are 0 whenever their ready is 0.

## Timing
- Reset: state IDLE, counters 0, owner FETCH; `mem_en`, `mem_we`, `if_ready`, `d_ready` = 0; all data/address outputs = 0.
- `rst` takes effect mid-access and discards the access. No ready fires, and the next cycle is IDLE.
- Grant in cycle T gives read ready at T+MEM_LATENCY and write ready at T+1.
- Throughput: one read per MEM_LATENCY+1 cycles, one write per 2 cycles.
- `mem_en` is never high in two consecutive cycles. `if_ready` and `d_ready` are never high together.

## Structure
- Shared package `mem_arb_pkg`: state enum {IDLE, BUSY}, owner enum {OWN_FETCH, OWN_DATA}.
- Single module. The starve counter is small enough to stay inline, so no sub-module is needed.

## Test plan
MEM_LATENCY=2 and STARVE_LIMIT=4 unless noted.
- Lone fetch: `if_req`=1, addr 0x100, `mem_rdata`=0xDEADBEEF at T+2 → `mem_en` at T only; `if_ready`=1 with `if_rdata`=0xDEADBEEF at T+2; IDLE at T+3.
- Simultaneous requests: fetch 0x200 and load 0x40 issued together → load granted at T with ready at T+2; fetch granted at T+3 with ready at T+5.
- Store: `d_we`=1, addr 0x80, wdata 0x12345678 → `mem_en`=`mem_we`=1 with matching addr/data at T; `d_ready` at T+1.
- Starvation: `d_req` held with back-to-back loads, `if_req` held → fetch loses exactly 4 arbitrations and wins the 5th; counter back to 0.
- Flush: fetch granted at T, `if_req` dropped at T+1 → `if_ready` stays 0 at T+2; a new `if_req` at T+2 is granted at T+3.
- Reset mid-read: `rst` asserted at T+1 → no ready at T+2; outputs at reset values; a fresh request is granted on the first cycle after `rst` deasserts.
